caf_peak_search: RTL and testbench



---
 rtl/caf_peak_search.sv | 117 +++++++++++
 tb/tb_caf_peak_search.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/caf_peak_search.sv
// Peak search over the per-frequency correlator results: scans FOA_LEN bins one per clock,
// tracks the strongest and runner-up magnitudes, and emits {detect, bin, lag} over a stream handshake.
module caf_peak_search #(
  parameter int FOA_LEN      = 8,
  parameter int FOA_BITS     = 3,
  parameter int OUT_MAX_BITS = 32,
  parameter int INDEX_BITS   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               m_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic [FOA_LEN*OUT_MAX_BITS-1:0]    m_axis_max,
  input  logic [FOA_LEN*INDEX_BITS-1:0]      m_axis_index,
  input  logic [OUT_MAX_BITS-1:0]            threshold,
  output logic                               s_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [FOA_BITS+INDEX_BITS:0]       s_axis_tdata,
  output logic [OUT_MAX_BITS-1:0]            s_axis_peak,
  output logic [OUT_MAX_BITS-1:0]            s_axis_second
);

  localparam logic [FOA_BITS-1:0] LAST_BIN = FOA_BITS'(FOA_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, PACK, OUTPUT} state_t;

  state_t                  state;
  logic [FOA_BITS-1:0]     ptr;

  logic [OUT_MAX_BITS-1:0] max_buf [FOA_LEN];
  logic [INDEX_BITS-1:0]   idx_buf [FOA_LEN];
  logic [OUT_MAX_BITS-1:0] thr_buf;

  logic [OUT_MAX_BITS-1:0] best;
  logic [OUT_MAX_BITS-1:0] runner;
  logic [FOA_BITS-1:0]     freq;
  logic [INDEX_BITS-1:0]   idx;

  logic [OUT_MAX_BITS-1:0] cur_max;
  logic [INDEX_BITS-1:0]   cur_idx;

  assign cur_max = max_buf[ptr];
  assign cur_idx = idx_buf[ptr];

  // Control and output registers take reset; the scan buffers and running
  // best/runner-up are always overwritten before use, so they carry none.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      s_axis_tready <= 1'b0;
      s_axis_tvalid <= 1'b0;
      s_axis_tdata  <= '0;
      s_axis_peak   <= '0;
      s_axis_second <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tready && m_axis_tvalid) begin
            for (int k = 0; k < FOA_LEN; k++) begin
              max_buf[k] <= m_axis_max[k*OUT_MAX_BITS +: OUT_MAX_BITS];
              idx_buf[k] <= m_axis_index[k*INDEX_BITS +: INDEX_BITS];
            end
            thr_buf       <= threshold;
            s_axis_tready <= 1'b0;
            ptr           <= '0;
            state         <= SCAN;
          end else begin
            s_axis_tready <= 1'b1;
          end
        end

        // Bin 0 seeds the search; later bins displace only on a strictly
        // larger magnitude, so ties resolve to the lowest bin number.
        SCAN: begin
          if (ptr == '0) begin
            best   <= cur_max;
            runner <= '0;
            freq   <= '0;
            idx    <= cur_idx;
          end else if (cur_max > best) begin
            runner <= best;
            best   <= cur_max;
            freq   <= ptr;
            idx    <= cur_idx;
          end else if (cur_max > runner) begin
            runner <= cur_max;
          end
          if (ptr == LAST_BIN) begin
            state <= PACK;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end

        PACK: begin
          s_axis_tdata  <= {(best >= thr_buf), freq, idx};
          s_axis_peak   <= best;
          s_axis_second <= runner;
          s_axis_tvalid <= 1'b1;
          state         <= OUTPUT;
        end

        OUTPUT: begin
          if (m_axis_tready) begin
            s_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caf_peak_search.sv
// Directed bench for caf_peak_search at FOA_LEN=4, 16-bit magnitudes: hand-computed results,
// latency, backpressure hold, ignored inputs while busy, and abort by reset mid-scan.
module tb_caf_peak_search;

  localparam int FL = 4;
  localparam int FB = 2;
  localparam int MW = 16;
  localparam int IW = 8;
  localparam int TW = 1 + FB + IW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [FL*MW-1:0]  m_axis_max = '0;
  logic [FL*IW-1:0]  m_axis_index = '0;
  logic [MW-1:0]     threshold = '0;
  logic              s_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [TW-1:0]     s_axis_tdata;
  logic [MW-1:0]     s_axis_peak;
  logic [MW-1:0]     s_axis_second;

  int n_vec = 0;
  int n_bad = 0;

  caf_peak_search #(
    .FOA_LEN(FL), .FOA_BITS(FB), .OUT_MAX_BITS(MW), .INDEX_BITS(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_max(m_axis_max), .m_axis_index(m_axis_index), .threshold(threshold),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_peak(s_axis_peak), .s_axis_second(s_axis_second)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic accept_set(input string tag, input logic [FL*MW-1:0] mx,
                            input logic [FL*IW-1:0] ix, input logic [MW-1:0] thr);
    int n = 0;
    while (!s_axis_tready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_eq({tag, ".ready"}, 64'(s_axis_tready), 64'd1);
    m_axis_max    = mx;
    m_axis_index  = ix;
    threshold     = thr;
    m_axis_tvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    m_axis_tvalid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic det, input logic [FB-1:0] fq,
                             input logic [IW-1:0] ix, input logic [MW-1:0] pk,
                             input logic [MW-1:0] sc);
    int lat = 0;
    while (!s_axis_tvalid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(FL + 1));
    check_eq({tag, ".detect"}, 64'(s_axis_tdata[TW-1]), 64'(det));
    check_eq({tag, ".freq"}, 64'(s_axis_tdata[IW +: FB]), 64'(fq));
    check_eq({tag, ".index"}, 64'(s_axis_tdata[IW-1:0]), 64'(ix));
    check_eq({tag, ".peak"}, 64'(s_axis_peak), 64'(pk));
    check_eq({tag, ".second"}, 64'(s_axis_second), 64'(sc));
  endtask

  task automatic release_out(input string tag);
    m_axis_tready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq({tag, ".tvalid_drop"}, 64'(s_axis_tvalid), 64'd0);
    check_eq({tag, ".ready_back"}, 64'(s_axis_tready), 64'd1);
  endtask

  initial begin
    logic [TW-1:0] td_snap;
    logic [MW-1:0] pk_snap, sc_snap;
    logic          seen;

    @(negedge clk);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_eq("rst.tready", 64'(s_axis_tready), 64'd0);
    check_eq("rst.tvalid", 64'(s_axis_tvalid), 64'd0);
    check_eq("rst.tdata", 64'(s_axis_tdata), 64'd0);
    check_eq("rst.peak", 64'(s_axis_peak), 64'd0);
    check_eq("rst.second", 64'(s_axis_second), 64'd0);
    rst = 1'b0;
    check_eq("rst.ready_low", 64'(s_axis_tready), 64'd0);
    @(posedge clk); @(negedge clk);
    check_eq("rst.ready_up", 64'(s_axis_tready), 64'd1);

    // Winner in bin 1, runner-up from bin 2, detect above threshold.
    accept_set("t1", {16'd20, 16'd30, 16'd50, 16'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 16'd40);
    wait_result("t1", 1'b1, 2'd1, 8'd2, 16'd50, 16'd30);
    release_out("t1");

    accept_set("t2", {16'd20, 16'd30, 16'd50, 16'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 16'd60);
    wait_result("t2", 1'b0, 2'd1, 8'd2, 16'd50, 16'd30);
    release_out("t2");

    // Equal magnitudes: bin 0 keeps the win, runner-up equals peak.
    accept_set("t3", {16'd7, 16'd7, 16'd7, 16'd7}, {8'd44, 8'd33, 8'd22, 8'd11}, 16'd5);
    wait_result("t3", 1'b1, 2'd0, 8'd11, 16'd7, 16'd7);
    release_out("t3");

    accept_set("t4", '0, {8'd9, 8'd8, 8'd7, 8'd6}, 16'd0);
    wait_result("t4", 1'b1, 2'd0, 8'd6, 16'd0, 16'd0);
    release_out("t4");

    // Threshold equal to peak detects; full-width unsigned magnitudes.
    accept_set("t4b", {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001}, {8'd4, 8'd3, 8'd2, 8'd1}, 16'hFFFF);
    wait_result("t4b", 1'b1, 2'd3, 8'd4, 16'hFFFF, 16'h8000);
    release_out("t4b");

    // Backpressure with an ignored input pulse in the window.
    m_axis_tready = 1'b0;
    accept_set("t5", {16'd5, 16'd90, 16'd3, 16'd60}, {8'd14, 8'd13, 8'd12, 8'd11}, 16'd100);
    wait_result("t5", 1'b0, 2'd2, 8'd13, 16'd90, 16'd60);
    td_snap = s_axis_tdata; pk_snap = s_axis_peak; sc_snap = s_axis_second;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        m_axis_max = '1; m_axis_index = '1; threshold = '0; m_axis_tvalid = 1'b1;
      end else begin
        m_axis_tvalid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      check_eq("t5.hold_valid", 64'(s_axis_tvalid), 64'd1);
      check_eq("t5.hold_tdata", 64'(s_axis_tdata), 64'(td_snap));
      check_eq("t5.hold_peak", 64'(s_axis_peak), 64'(pk_snap));
      check_eq("t5.hold_second", 64'(s_axis_second), 64'(sc_snap));
      check_eq("t5.hold_ready", 64'(s_axis_tready), 64'd0);
    end
    m_axis_tvalid = 1'b0;
    release_out("t5");
    accept_set("t5b", {16'd1, 16'd2, 16'd40, 16'd3}, {8'd24, 8'd23, 8'd22, 8'd21}, 16'd40);
    wait_result("t5b", 1'b1, 2'd1, 8'd22, 16'd40, 16'd3);
    release_out("t5b");

    // Abort during the scan at ptr=2, then a fresh set.
    accept_set("t6", {16'd100, 16'd200, 16'd300, 16'd400}, {8'd4, 8'd3, 8'd2, 8'd1}, 16'd0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (s_axis_tvalid) seen = 1'b1;
    end
    check_eq("t6.no_stale", 64'(seen), 64'd0);
    accept_set("t6b", {16'd4, 16'd3, 16'd2, 16'd1}, {8'd40, 8'd30, 8'd20, 8'd10}, 16'd4);
    wait_result("t6b", 1'b1, 2'd3, 8'd40, 16'd4, 16'd3);
    release_out("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
